// File: rtl/dcache_write_pipe_pkg.sv
// Shared definitions for the dcache write pipe: widths, FSM states, address slicing.
package dcache_write_pipe_pkg;

  localparam int unsigned TAG_W = 20;
  localparam int unsigned SET_W = 8;
  localparam int unsigned WAY_W = 8;
  localparam int unsigned WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    WB    = 2'd2,
    RESP  = 2'd3
  } wp_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:12];
  endfunction

  function automatic logic [SET_W-1:0] addr_set(input logic [31:0] a);
    return a[11:4];
  endfunction

  function automatic logic [1:0] addr_word(input logic [31:0] a);
    return a[3:2];
  endfunction

endpackage

// File: rtl/dcache_write_pipe_store_merge.sv
// Byte-masked merge of store data into one word of a cache line (combinational).
module store_merge
  import dcache_write_pipe_pkg::*;
(
  input  logic [WORDS-1:0][31:0] line,
  input  logic [1:0]             word,
  input  logic [31:0]            store_data,
  input  logic [3:0]             store_mask,
  output logic [WORDS-1:0][31:0] merged
);

  always_comb begin
    merged = line;
    for (int unsigned b = 0; b < 4; b++) begin
      if (store_mask[b]) merged[word][8*b +: 8] = store_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_write_pipe.sv
// Dcache write pipe: store-hit merge/commit and dirty-victim 4-beat writeback.
// Optional perf counters enabled by WRITE_PIPE_PERF_EN.
module dcache_write_pipe
  import dcache_write_pipe_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  output logic             io_in_ready,
  input  logic             io_in_valid,
  input  logic [31:0]      io_in_bits_addr,
  input  logic             io_in_bits_dirInfo_hit,
  input  logic [WAY_W-1:0] io_in_bits_dirInfo_chosenWay,
  input  logic             io_in_bits_dirInfo_isDirtyWay,
  input  logic [TAG_W-1:0] io_in_bits_dirInfo_dirtyTag,
  input  logic [31:0]      io_in_bits_data_0,
  input  logic [31:0]      io_in_bits_data_1,
  input  logic [31:0]      io_in_bits_data_2,
  input  logic [31:0]      io_in_bits_data_3,
  input  logic             io_in_bits_isStore,
  input  logic [31:0]      io_in_bits_storeData,
  input  logic [3:0]       io_in_bits_storeMask,
  output logic             io_dataWrite_valid,
  output logic [SET_W-1:0] io_dataWrite_bits_set,
  output logic [WAY_W-1:0] io_dataWrite_bits_way,
  output logic [31:0]      io_dataWrite_bits_data_0,
  output logic [31:0]      io_dataWrite_bits_data_1,
  output logic [31:0]      io_dataWrite_bits_data_2,
  output logic [31:0]      io_dataWrite_bits_data_3,
  output logic             io_dirWrite_valid,
  output logic [SET_W-1:0] io_dirWrite_bits_set,
  output logic [WAY_W-1:0] io_dirWrite_bits_way,
  output logic [TAG_W-1:0] io_dirWrite_bits_tag,
  output logic             io_dirWrite_bits_dirty,
  output logic             io_wb_valid,
  input  logic             io_wb_ready,
  output logic [31:0]      io_wb_bits_addr,
  output logic [31:0]      io_wb_bits_data,
  output logic             io_wb_bits_last,
  output logic             io_resp_valid,
  output logic             io_resp_bits_isStore
`ifdef WRITE_PIPE_PERF_EN
  ,
  output logic [31:0]      io_perf_storeCnt,
  output logic [31:0]      io_perf_wbCnt,
  output logic [31:0]      io_perf_wbStallCnt
`endif
);

  wp_state_t state_q, state_d;

  logic [1:0]             cnt_q;
  logic                   from_wb_q;
  logic [TAG_W-1:0]       tag_q;
  logic [SET_W-1:0]       set_q;
  logic [1:0]             word_q;
  logic [WAY_W-1:0]       way_q;
  logic [TAG_W-1:0]       dtag_q;
  logic [WORDS-1:0][31:0] data_q;
  logic                   is_store_q;
  logic [31:0]            sdata_q;
  logic [3:0]             smask_q;
  logic [WORDS-1:0][31:0] merged;

  logic fire;
  logic wb_fire;
  logic unused_addr_lsb;

  // Byte offset within a word never affects line placement.
  assign unused_addr_lsb = &{1'b0, io_in_bits_addr[1:0]};

  assign fire    = io_in_valid && (state_q == IDLE);
  assign wb_fire = (state_q == WB) && io_wb_ready;

  store_merge u_store_merge (
    .line       (data_q),
    .word       (word_q),
    .store_data (sdata_q),
    .store_mask (smask_q),
    .merged     (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      from_wb_q  <= 1'b0;
      tag_q      <= '0;
      set_q      <= '0;
      word_q     <= '0;
      way_q      <= '0;
      dtag_q     <= '0;
      data_q     <= '0;
      is_store_q <= 1'b0;
      sdata_q    <= '0;
      smask_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        cnt_q      <= '0;
        from_wb_q  <= 1'b0;
        tag_q      <= addr_tag(io_in_bits_addr);
        set_q      <= addr_set(io_in_bits_addr);
        word_q     <= addr_word(io_in_bits_addr);
        way_q      <= io_in_bits_dirInfo_chosenWay;
        dtag_q     <= io_in_bits_dirInfo_dirtyTag;
        data_q     <= {io_in_bits_data_3, io_in_bits_data_2,
                       io_in_bits_data_1, io_in_bits_data_0};
        is_store_q <= io_in_bits_isStore;
        sdata_q    <= io_in_bits_storeData;
        smask_q    <= io_in_bits_storeMask;
      end
      if (wb_fire) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) from_wb_q <= 1'b1;
      end
      if (state_q == RESP) from_wb_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (io_in_bits_isStore && io_in_bits_dirInfo_hit)
            state_d = STORE;
          else if (!io_in_bits_dirInfo_hit && io_in_bits_dirInfo_isDirtyWay)
            state_d = WB;
          else
            state_d = RESP;
        end
      end
      STORE:   state_d = IDLE;
      WB:      if (wb_fire && (cnt_q == 2'd3)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_in_ready              = (state_q == IDLE);
    io_dataWrite_valid       = 1'b0;
    io_dataWrite_bits_set    = '0;
    io_dataWrite_bits_way    = '0;
    io_dataWrite_bits_data_0 = '0;
    io_dataWrite_bits_data_1 = '0;
    io_dataWrite_bits_data_2 = '0;
    io_dataWrite_bits_data_3 = '0;
    io_dirWrite_valid        = 1'b0;
    io_dirWrite_bits_set     = '0;
    io_dirWrite_bits_way     = '0;
    io_dirWrite_bits_tag     = '0;
    io_dirWrite_bits_dirty   = 1'b0;
    io_wb_valid              = 1'b0;
    io_wb_bits_addr          = '0;
    io_wb_bits_data          = '0;
    io_wb_bits_last          = 1'b0;
    io_resp_valid            = 1'b0;
    io_resp_bits_isStore     = 1'b0;
    case (state_q)
      STORE: begin
        io_dataWrite_valid       = 1'b1;
        io_dataWrite_bits_set    = set_q;
        io_dataWrite_bits_way    = way_q;
        io_dataWrite_bits_data_0 = merged[0];
        io_dataWrite_bits_data_1 = merged[1];
        io_dataWrite_bits_data_2 = merged[2];
        io_dataWrite_bits_data_3 = merged[3];
        io_dirWrite_valid        = 1'b1;
        io_dirWrite_bits_set     = set_q;
        io_dirWrite_bits_way     = way_q;
        io_dirWrite_bits_tag     = tag_q;
        io_dirWrite_bits_dirty   = 1'b1;
        io_resp_valid            = 1'b1;
        io_resp_bits_isStore     = 1'b1;
      end
      WB: begin
        io_wb_valid     = 1'b1;
        io_wb_bits_addr = {dtag_q, set_q, cnt_q, 2'b00};
        io_wb_bits_data = data_q[cnt_q];
        io_wb_bits_last = (cnt_q == 2'd3);
      end
      RESP: begin
        io_resp_valid        = 1'b1;
        io_resp_bits_isStore = is_store_q;
        if (from_wb_q) begin
          io_dirWrite_valid      = 1'b1;
          io_dirWrite_bits_set   = set_q;
          io_dirWrite_bits_way   = way_q;
          io_dirWrite_bits_tag   = dtag_q;
          io_dirWrite_bits_dirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

`ifdef WRITE_PIPE_PERF_EN
  logic [31:0] store_cnt_q, wb_cnt_q, wb_stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      store_cnt_q    <= '0;
      wb_cnt_q       <= '0;
      wb_stall_cnt_q <= '0;
    end else begin
      if (state_q == STORE) store_cnt_q <= store_cnt_q + 32'd1;
      if (wb_fire && (cnt_q == 2'd3)) wb_cnt_q <= wb_cnt_q + 32'd1;
      if ((state_q == WB) && !io_wb_ready) wb_stall_cnt_q <= wb_stall_cnt_q + 32'd1;
    end
  end

  assign io_perf_storeCnt   = store_cnt_q;
  assign io_perf_wbCnt      = wb_cnt_q;
  assign io_perf_wbStallCnt = wb_stall_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_write_pipe.sv
// Directed self-checking bench for dcache_write_pipe (perf section under WRITE_PIPE_PERF_EN).
module tb_dcache_write_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_ready;
  logic        io_in_valid;
  logic [31:0] io_in_bits_addr;
  logic        io_in_bits_dirInfo_hit;
  logic [7:0]  io_in_bits_dirInfo_chosenWay;
  logic        io_in_bits_dirInfo_isDirtyWay;
  logic [19:0] io_in_bits_dirInfo_dirtyTag;
  logic [31:0] io_in_bits_data_0, io_in_bits_data_1, io_in_bits_data_2, io_in_bits_data_3;
  logic        io_in_bits_isStore;
  logic [31:0] io_in_bits_storeData;
  logic [3:0]  io_in_bits_storeMask;
  logic        io_dataWrite_valid;
  logic [7:0]  io_dataWrite_bits_set, io_dataWrite_bits_way;
  logic [31:0] io_dataWrite_bits_data_0, io_dataWrite_bits_data_1;
  logic [31:0] io_dataWrite_bits_data_2, io_dataWrite_bits_data_3;
  logic        io_dirWrite_valid;
  logic [7:0]  io_dirWrite_bits_set, io_dirWrite_bits_way;
  logic [19:0] io_dirWrite_bits_tag;
  logic        io_dirWrite_bits_dirty;
  logic        io_wb_valid, io_wb_ready;
  logic [31:0] io_wb_bits_addr, io_wb_bits_data;
  logic        io_wb_bits_last;
  logic        io_resp_valid, io_resp_bits_isStore;
`ifdef WRITE_PIPE_PERF_EN
  logic [31:0] io_perf_storeCnt, io_perf_wbCnt, io_perf_wbStallCnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  dcache_write_pipe dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_ready                   (io_in_ready),
    .io_in_valid                   (io_in_valid),
    .io_in_bits_addr               (io_in_bits_addr),
    .io_in_bits_dirInfo_hit        (io_in_bits_dirInfo_hit),
    .io_in_bits_dirInfo_chosenWay  (io_in_bits_dirInfo_chosenWay),
    .io_in_bits_dirInfo_isDirtyWay (io_in_bits_dirInfo_isDirtyWay),
    .io_in_bits_dirInfo_dirtyTag   (io_in_bits_dirInfo_dirtyTag),
    .io_in_bits_data_0             (io_in_bits_data_0),
    .io_in_bits_data_1             (io_in_bits_data_1),
    .io_in_bits_data_2             (io_in_bits_data_2),
    .io_in_bits_data_3             (io_in_bits_data_3),
    .io_in_bits_isStore            (io_in_bits_isStore),
    .io_in_bits_storeData          (io_in_bits_storeData),
    .io_in_bits_storeMask          (io_in_bits_storeMask),
    .io_dataWrite_valid            (io_dataWrite_valid),
    .io_dataWrite_bits_set         (io_dataWrite_bits_set),
    .io_dataWrite_bits_way         (io_dataWrite_bits_way),
    .io_dataWrite_bits_data_0      (io_dataWrite_bits_data_0),
    .io_dataWrite_bits_data_1      (io_dataWrite_bits_data_1),
    .io_dataWrite_bits_data_2      (io_dataWrite_bits_data_2),
    .io_dataWrite_bits_data_3      (io_dataWrite_bits_data_3),
    .io_dirWrite_valid             (io_dirWrite_valid),
    .io_dirWrite_bits_set          (io_dirWrite_bits_set),
    .io_dirWrite_bits_way          (io_dirWrite_bits_way),
    .io_dirWrite_bits_tag          (io_dirWrite_bits_tag),
    .io_dirWrite_bits_dirty        (io_dirWrite_bits_dirty),
    .io_wb_valid                   (io_wb_valid),
    .io_wb_ready                   (io_wb_ready),
    .io_wb_bits_addr               (io_wb_bits_addr),
    .io_wb_bits_data               (io_wb_bits_data),
    .io_wb_bits_last               (io_wb_bits_last),
    .io_resp_valid                 (io_resp_valid),
    .io_resp_bits_isStore          (io_resp_bits_isStore)
`ifdef WRITE_PIPE_PERF_EN
    ,
    .io_perf_storeCnt              (io_perf_storeCnt),
    .io_perf_wbCnt                 (io_perf_wbCnt),
    .io_perf_wbStallCnt            (io_perf_wbStallCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_line(input logic [31:0] d0, d1, d2, d3);
    io_in_bits_data_0 = d0;
    io_in_bits_data_1 = d1;
    io_in_bits_data_2 = d2;
    io_in_bits_data_3 = d3;
  endtask

  // Present one request and let it fire on the next edge (caller ensures ready).
  task automatic send(input logic [31:0] addr, input logic hit, input logic [7:0] way,
                      input logic dirty, input logic [19:0] dtag, input logic st,
                      input logic [31:0] sdata, input logic [3:0] smask);
    io_in_valid                   = 1'b1;
    io_in_bits_addr               = addr;
    io_in_bits_dirInfo_hit        = hit;
    io_in_bits_dirInfo_chosenWay  = way;
    io_in_bits_dirInfo_isDirtyWay = dirty;
    io_in_bits_dirInfo_dirtyTag   = dtag;
    io_in_bits_isStore            = st;
    io_in_bits_storeData          = sdata;
    io_in_bits_storeMask          = smask;
    tick();
    io_in_valid = 1'b0;
  endtask

  task automatic check_quiet_strobes(input string tag);
    check({tag, "_dwv"}, io_dataWrite_valid, 1'b0);
    check({tag, "_dirv"}, io_dirWrite_valid, 1'b0);
    check({tag, "_wbv"}, io_wb_valid, 1'b0);
  endtask

  // Run the burst of an already-fired dirty miss; pat[i] is wb_ready on burst cycle i.
  task automatic run_wb(input logic [7:0] pat, input logic [19:0] dtag,
                        input logic [7:0] set_idx, input logic [7:0] way);
    int unsigned beat = 0;
    logic [1:0] b2;
    for (int unsigned cyc = 0; cyc < 16 && beat < 4; cyc++) begin
      b2 = beat[1:0];
      io_wb_ready = pat[cyc % 8];
      check("wb_valid", io_wb_valid, 1'b1);
      check("wb_addr", io_wb_bits_addr, {dtag, set_idx, b2, 2'b00});
      check("wb_data", io_wb_bits_data, beat);
      check("wb_last", io_wb_bits_last, (beat == 3));
      check("wb_resp", io_resp_valid, 1'b0);
      check("wb_ready_in", io_in_ready, 1'b0);
      check("wb_dirv", io_dirWrite_valid, 1'b0);
      if (io_wb_ready) beat++;
      tick();
    end
    io_wb_ready = 1'b0;
    check("wb_beats_done", beat, 4);
    check("wbr_resp", io_resp_valid, 1'b1);
    check("wbr_isStore", io_resp_bits_isStore, 1'b0);
    check("wbr_dirv", io_dirWrite_valid, 1'b1);
    check("wbr_dirtag", io_dirWrite_bits_tag, dtag);
    check("wbr_dirset", io_dirWrite_bits_set, set_idx);
    check("wbr_dirway", io_dirWrite_bits_way, way);
    check("wbr_dirty", io_dirWrite_bits_dirty, 1'b0);
    check("wbr_wbv", io_wb_valid, 1'b0);
    check("wbr_ready", io_in_ready, 1'b0);
    tick();
    check("wbr_ready_after", io_in_ready, 1'b1);
    check("wbr_resp_after", io_resp_valid, 1'b0);
  endtask

  task automatic store_hit_basic();
    set_line(32'hA000_0000, 32'h1122_3344, 32'hA000_0002, 32'hA000_0003);
    send(32'h8000_1234, 1'b1, 8'h04, 1'b0, 20'h0, 1'b1, 32'hAABB_CCDD, 4'b0101);
  endtask

  initial begin
    reset                         = 1'b1;
    io_in_valid                   = 1'b0;
    io_in_bits_addr               = '0;
    io_in_bits_dirInfo_hit        = 1'b0;
    io_in_bits_dirInfo_chosenWay  = '0;
    io_in_bits_dirInfo_isDirtyWay = 1'b0;
    io_in_bits_dirInfo_dirtyTag   = '0;
    io_in_bits_isStore            = 1'b0;
    io_in_bits_storeData          = '0;
    io_in_bits_storeMask          = '0;
    io_wb_ready                   = 1'b0;
    set_line('0, '0, '0, '0);
    tick();
    tick();
    check("rst_resp", io_resp_valid, 1'b0);
    check_quiet_strobes("rst");
    reset = 1'b0;
    tick();
    check("rel_ready", io_in_ready, 1'b1);
    check("rel_resp", io_resp_valid, 1'b0);
    check_quiet_strobes("rel");

    // Store hit with partial mask into word 1.
    store_hit_basic();
    check("st_dwv", io_dataWrite_valid, 1'b1);
    check("st_d0", io_dataWrite_bits_data_0, 32'hA000_0000);
    check("st_d1", io_dataWrite_bits_data_1, 32'h11BB_33DD);
    check("st_d2", io_dataWrite_bits_data_2, 32'hA000_0002);
    check("st_d3", io_dataWrite_bits_data_3, 32'hA000_0003);
    check("st_set", io_dataWrite_bits_set, 8'h23);
    check("st_way", io_dataWrite_bits_way, 8'h04);
    check("st_dirv", io_dirWrite_valid, 1'b1);
    check("st_tag", io_dirWrite_bits_tag, 20'h80001);
    check("st_dirset", io_dirWrite_bits_set, 8'h23);
    check("st_dirway", io_dirWrite_bits_way, 8'h04);
    check("st_dirty", io_dirWrite_bits_dirty, 1'b1);
    check("st_resp", io_resp_valid, 1'b1);
    check("st_isStore", io_resp_bits_isStore, 1'b1);
    check("st_ready", io_in_ready, 1'b0);
    check("st_wbv", io_wb_valid, 1'b0);
    tick();
    check("st_ready2", io_in_ready, 1'b1);
    check("st_resp2", io_resp_valid, 1'b0);
    check("st_dwv2", io_dataWrite_valid, 1'b0);

    // Store hit with empty mask into word 3: line unchanged but still dirtied.
    set_line(32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'hDEAD_BEEF);
    send(32'h0000_00FC, 1'b1, 8'h80, 1'b0, 20'h0, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    check("st0_dwv", io_dataWrite_valid, 1'b1);
    check("st0_d3", io_dataWrite_bits_data_3, 32'hDEAD_BEEF);
    check("st0_d0", io_dataWrite_bits_data_0, 32'h0101_0101);
    check("st0_set", io_dataWrite_bits_set, 8'h0F);
    check("st0_way", io_dataWrite_bits_way, 8'h80);
    check("st0_dirty", io_dirWrite_bits_dirty, 1'b1);
    check("st0_tag", io_dirWrite_bits_tag, 20'h00000);
    tick();

    // Full-mask store into word 0.
    set_line(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    send(32'hCAFE_0A00, 1'b1, 8'h01, 1'b1, 20'h0, 1'b1, 32'h5566_7788, 4'b1111);
    check("stf_d0", io_dataWrite_bits_data_0, 32'h5566_7788);
    check("stf_d1", io_dataWrite_bits_data_1, 32'h2222_2222);
    check("stf_set", io_dataWrite_bits_set, 8'hA0);
    check("stf_tag", io_dirWrite_bits_tag, 20'hCAFE0);
    tick();

    // Dirty miss with wb_ready toggling 0/1.
    set_line(32'd0, 32'd1, 32'd2, 32'd3);
    send(32'hFFFF_F230, 1'b0, 8'h02, 1'b1, 20'h12345, 1'b0, 32'h0, 4'h0);
    run_wb(8'b1010_1010, 20'h12345, 8'h23, 8'h02);

    // Load hit then clean miss with valid held high.
    set_line(32'h5, 32'h6, 32'h7, 32'h8);
    send(32'h0000_0040, 1'b1, 8'h01, 1'b1, 20'hABCDE, 1'b0, 32'h0, 4'hF);
    io_in_valid = 1'b1;
    check("lh_resp", io_resp_valid, 1'b1);
    check("lh_isStore", io_resp_bits_isStore, 1'b0);
    check("lh_ready", io_in_ready, 1'b0);
    check_quiet_strobes("lh");
    io_in_bits_dirInfo_hit        = 1'b0;
    io_in_bits_dirInfo_isDirtyWay = 1'b0;
    tick();
    check("cm_idle_ready", io_in_ready, 1'b1);
    check("cm_idle_resp", io_resp_valid, 1'b0);
    tick();
    io_in_valid = 1'b0;
    check("cm_resp", io_resp_valid, 1'b1);
    check("cm_isStore", io_resp_bits_isStore, 1'b0);
    check("cm_ready", io_in_ready, 1'b0);
    check_quiet_strobes("cm");
    tick();
    check("cm_ready2", io_in_ready, 1'b1);
    check("cm_resp2", io_resp_valid, 1'b0);

    // Store miss is dropped but still answered.
    send(32'h1234_5678, 1'b0, 8'h04, 1'b0, 20'h0, 1'b1, 32'h1, 4'hF);
    check("sm_resp", io_resp_valid, 1'b1);
    check("sm_isStore", io_resp_bits_isStore, 1'b1);
    check_quiet_strobes("sm");
    tick();
    check("sm_ready2", io_in_ready, 1'b1);

    // Reset during beat 2 abandons the burst.
    set_line(32'h10, 32'h11, 32'h12, 32'h13);
    io_wb_ready = 1'b1;
    send(32'h0000_0550, 1'b0, 8'h08, 1'b1, 20'h0BEEF, 1'b0, 32'h0, 4'h0);
    check("rb_b0_addr", io_wb_bits_addr, 32'h0BEE_F550);
    tick();
    tick();
    check("rb_b2_addr", io_wb_bits_addr, 32'h0BEE_F558);
    check("rb_b2_data", io_wb_bits_data, 32'h12);
    reset = 1'b1;
    tick();
    check("rb_wbv", io_wb_valid, 1'b0);
    check("rb_resp", io_resp_valid, 1'b0);
    check("rb_ready", io_in_ready, 1'b1);
    reset = 1'b0;
    io_wb_ready = 1'b0;
    tick();
    check("rb_ready_rel", io_in_ready, 1'b1);
    check("rb_wbv_rel", io_wb_valid, 1'b0);
    check("rb_dirv_rel", io_dirWrite_valid, 1'b0);
    // Next writeback starts from beat 0 again.
    set_line(32'd0, 32'd1, 32'd2, 32'd3);
    send(32'h0000_0550, 1'b0, 8'h08, 1'b1, 20'h0BEEF, 1'b0, 32'h0, 4'h0);
    run_wb(8'b1111_1111, 20'h0BEEF, 8'h55, 8'h08);

`ifdef WRITE_PIPE_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("pf_rst_store", io_perf_storeCnt, 32'd0);
    check("pf_rst_wb", io_perf_wbCnt, 32'd0);
    check("pf_rst_stall", io_perf_wbStallCnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      store_hit_basic();
      tick();
    end
    set_line(32'd0, 32'd1, 32'd2, 32'd3);
    send(32'hFFFF_F230, 1'b0, 8'h02, 1'b1, 20'h12345, 1'b0, 32'h0, 4'h0);
    run_wb(8'b1111_1010, 20'h12345, 8'h23, 8'h02);
    check("pf_store", io_perf_storeCnt, 32'd3);
    check("pf_wb", io_perf_wbCnt, 32'd1);
    check("pf_stall", io_perf_wbStallCnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
